// File: rtl/easyaxi_rd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : easyaxi_rd_arb_pkg
// Purpose  : Shared EasyAXI bus widths/codes and read-arbiter master indexing.
// Revision : 1.0  initial release
// ============================================================================

`ifndef EASYAXI_DEFINE_SVH
`define EASYAXI_DEFINE_SVH
`define AXI_ID_W        4
`define AXI_ADDR_W      32
`define AXI_LEN_W       8
`define AXI_SIZE_W      3
`define AXI_BURST_W     2
`define AXI_DATA_W      32
`define AXI_RESP_W      2
`define AXI_BURST_FIXED 2'b00
`define AXI_BURST_INCR  2'b01
`define AXI_BURST_WRAP  2'b10
`define AXI_RESP_OKAY   2'b00
`define AXI_RESP_EXOKAY 2'b01
`define AXI_RESP_SLVERR 2'b10
`define AXI_RESP_DECERR 2'b11
`endif

package easyaxi_rd_arb_pkg;
    localparam int MST_NUM   = 2;
    localparam int MST_IDX_W = 1;

    typedef struct packed {
        logic [`AXI_ID_W-1:0]    id;
        logic [`AXI_ADDR_W-1:0]  addr;
        logic [`AXI_LEN_W-1:0]   len;
        logic [`AXI_SIZE_W-1:0]  size;
        logic [`AXI_BURST_W-1:0] burst;
    } ar_req_t;
endpackage

`default_nettype wire

// File: rtl/easyaxi_rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : easyaxi_rr_arb2
// Purpose  : Two-way round-robin grant with a last-grant register.
// Revision : 1.0  initial release
// ============================================================================

module easyaxi_rr_arb2
    import easyaxi_rd_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [MST_NUM-1:0] elig,
    input  logic [MST_NUM-1:0] room,
    input  logic               upd_en,
    output logic [MST_NUM-1:0] grant
);

    logic r_last_grant;

    // A grant is an offer built from the other master's eligibility and this
    // master's own room only, so a ready never waits on its own valid.
    always_comb begin
        grant    = '0;
        grant[0] = room[0] & (~elig[1] | r_last_grant);
        grant[1] = room[1] & (~elig[0] | ~r_last_grant);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= 1'b1;
        end else if (upd_en) begin
            if (elig[0] & grant[0]) begin
                r_last_grant <= 1'b0;
            end else if (elig[1] & grant[1]) begin
                r_last_grant <= 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/easyaxi_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : easyaxi_rd_arb
// Purpose  : 2:1 AXI read arbiter with registered AR stage and ID-based R routing.
// Revision : 1.0  initial release
// ============================================================================

module easyaxi_rd_arb
    import easyaxi_rd_arb_pkg::*;
#(
    parameter int MAX_OST = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    m0_arvalid,
    output logic                    m0_arready,
    input  logic [`AXI_ID_W-2:0]    m0_arid,
    input  logic [`AXI_ADDR_W-1:0]  m0_araddr,
    input  logic [`AXI_LEN_W-1:0]   m0_arlen,
    input  logic [`AXI_SIZE_W-1:0]  m0_arsize,
    input  logic [`AXI_BURST_W-1:0] m0_arburst,
    output logic                    m0_rvalid,
    input  logic                    m0_rready,
    output logic [`AXI_ID_W-2:0]    m0_rid,
    output logic [`AXI_DATA_W-1:0]  m0_rdata,
    output logic [`AXI_RESP_W-1:0]  m0_rresp,
    output logic                    m0_rlast,
    input  logic                    m1_arvalid,
    output logic                    m1_arready,
    input  logic [`AXI_ID_W-2:0]    m1_arid,
    input  logic [`AXI_ADDR_W-1:0]  m1_araddr,
    input  logic [`AXI_LEN_W-1:0]   m1_arlen,
    input  logic [`AXI_SIZE_W-1:0]  m1_arsize,
    input  logic [`AXI_BURST_W-1:0] m1_arburst,
    output logic                    m1_rvalid,
    input  logic                    m1_rready,
    output logic [`AXI_ID_W-2:0]    m1_rid,
    output logic [`AXI_DATA_W-1:0]  m1_rdata,
    output logic [`AXI_RESP_W-1:0]  m1_rresp,
    output logic                    m1_rlast,
    output logic                    s_arvalid,
    input  logic                    s_arready,
    output logic [`AXI_ID_W-1:0]    s_arid,
    output logic [`AXI_ADDR_W-1:0]  s_araddr,
    output logic [`AXI_LEN_W-1:0]   s_arlen,
    output logic [`AXI_SIZE_W-1:0]  s_arsize,
    output logic [`AXI_BURST_W-1:0] s_arburst,
    input  logic                    s_rvalid,
    output logic                    s_rready,
    input  logic [`AXI_ID_W-1:0]    s_rid,
    input  logic [`AXI_DATA_W-1:0]  s_rdata,
    input  logic [`AXI_RESP_W-1:0]  s_rresp,
    input  logic                    s_rlast,
    output logic                    ost_err
);

    localparam int                   OST_CNT_W = $clog2(MAX_OST + 1);
    localparam logic [OST_CNT_W-1:0] MAX_CNT   = OST_CNT_W'(MAX_OST);

    logic               r_s_arvalid;
    ar_req_t            r_s_ar;
    logic               r_ost_err;
    logic               w_load;
    logic               w_sel;
    logic [MST_NUM-1:0] w_room;
    logic [MST_NUM-1:0] w_elig;
    logic [MST_NUM-1:0] w_grant;
    logic [MST_NUM-1:0] w_inc;
    logic [MST_NUM-1:0] w_dec;
    logic [MST_NUM-1:0] w_unf;
    ar_req_t            w_m0_req;
    ar_req_t            w_m1_req;

    assign w_load = ~r_s_arvalid | s_arready;
    assign w_elig = {m1_arvalid, m0_arvalid} & w_room;

    easyaxi_rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .elig   (w_elig),
        .room   (w_room),
        .upd_en (w_load),
        .grant  (w_grant)
    );

    assign m0_arready = w_load & w_grant[0];
    assign m1_arready = w_load & w_grant[1];
    assign w_inc      = {m1_arvalid & m1_arready, m0_arvalid & m0_arready};

    // The master index rides in the ID MSB so R beats can find their way home.
    assign w_m0_req = '{id: {MST_IDX_W'(0), m0_arid}, addr: m0_araddr,
                        len: m0_arlen, size: m0_arsize, burst: m0_arburst};
    assign w_m1_req = '{id: {MST_IDX_W'(1), m1_arid}, addr: m1_araddr,
                        len: m1_arlen, size: m1_arsize, burst: m1_arburst};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s_arvalid <= 1'b0;
            r_s_ar      <= '0;
        end else if (w_load) begin
            r_s_arvalid <= |w_inc;
            if (w_inc[0]) begin
                r_s_ar <= w_m0_req;
            end else if (w_inc[1]) begin
                r_s_ar <= w_m1_req;
            end
        end
    end

    assign s_arvalid = r_s_arvalid;
    assign s_arid    = r_s_ar.id;
    assign s_araddr  = r_s_ar.addr;
    assign s_arlen   = r_s_ar.len;
    assign s_arsize  = r_s_ar.size;
    assign s_arburst = r_s_ar.burst;

    assign w_sel     = s_rid[`AXI_ID_W-1];
    assign m0_rvalid = s_rvalid & ~w_sel;
    assign m1_rvalid = s_rvalid & w_sel;
    assign s_rready  = w_sel ? m1_rready : m0_rready;
    assign m0_rid    = s_rid[`AXI_ID_W-2:0];
    assign m1_rid    = s_rid[`AXI_ID_W-2:0];
    assign m0_rdata  = s_rdata;
    assign m1_rdata  = s_rdata;
    assign m0_rresp  = s_rresp;
    assign m1_rresp  = s_rresp;
    assign m0_rlast  = s_rlast;
    assign m1_rlast  = s_rlast;
    assign w_dec     = {m1_rvalid & m1_rready & s_rlast, m0_rvalid & m0_rready & s_rlast};

    for (genvar n = 0; n < MST_NUM; n++) begin : g_ost
        logic [OST_CNT_W-1:0] r_cnt;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_inc[n] & ~w_dec[n]) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_dec[n] & ~w_inc[n] & (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end

        assign w_room[n] = r_cnt < MAX_CNT;
        assign w_unf[n]  = w_dec[n] & (r_cnt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ost_err <= 1'b0;
        end else if (|w_unf) begin
            r_ost_err <= 1'b1;
        end
    end

    assign ost_err = r_ost_err;

endmodule

`default_nettype wire

// File: tb/tb_easyaxi_rd_arb.sv
`default_nettype none
// ============================================================================
// Module   : tb_easyaxi_rd_arb
// Purpose  : Directed bench for easyaxi_rd_arb with a cycle-level reference model.
// Revision : 1.0  initial release
// ============================================================================

`ifndef AXI_ID_W
`define AXI_ID_W        4
`define AXI_ADDR_W      32
`define AXI_LEN_W       8
`define AXI_SIZE_W      3
`define AXI_BURST_W     2
`define AXI_DATA_W      32
`define AXI_RESP_W      2
`endif

module tb_easyaxi_rd_arb;

    localparam int MAXO = 2;

    typedef struct {
        logic [2:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } mreq_t;

    typedef struct {
        logic [3:0] id;
        logic       last;
    } rbeat_t;

    logic        clk, rst_n;
    logic        m0_arvalid, m0_arready, m1_arvalid, m1_arready;
    logic [2:0]  m0_arid, m1_arid, m0_rid, m1_rid;
    logic [31:0] m0_araddr, m1_araddr, m0_rdata, m1_rdata;
    logic [7:0]  m0_arlen, m1_arlen;
    logic [2:0]  m0_arsize, m1_arsize;
    logic [1:0]  m0_arburst, m1_arburst, m0_rresp, m1_rresp;
    logic        m0_rvalid, m0_rready, m0_rlast, m1_rvalid, m1_rready, m1_rlast;
    logic        s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, ost_err;
    logic [3:0]  s_arid, s_rid;
    logic [31:0] s_araddr, s_rdata;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst, s_rresp;

    easyaxi_rd_arb #(.MAX_OST(MAXO)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_arid(m0_arid),
        .m0_araddr(m0_araddr), .m0_arlen(m0_arlen), .m0_arsize(m0_arsize),
        .m0_arburst(m0_arburst), .m0_rvalid(m0_rvalid), .m0_rready(m0_rready),
        .m0_rid(m0_rid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rlast(m0_rlast),
        .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_arid(m1_arid),
        .m1_araddr(m1_araddr), .m1_arlen(m1_arlen), .m1_arsize(m1_arsize),
        .m1_arburst(m1_arburst), .m1_rvalid(m1_rvalid), .m1_rready(m1_rready),
        .m1_rid(m1_rid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rlast(m1_rlast),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
        .s_arburst(s_arburst), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
        .ost_err(ost_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    mreq_t  m0_q[$], m1_q[$];
    rbeat_t r_q[$];
    logic   issued[$];
    bit     auto_r  = 1'b0;
    bit     chk_en  = 1'b0;

    // ---------------- reference model ----------------
    int          m_cnt [2];
    bit          m_err, m_sv;
    int          m_pri;
    logic [3:0]  m_id;
    logic [31:0] m_addr;
    logic [7:0]  m_len;

    // Which master completes an AR handshake this cycle (-1: none).
    function automatic int exp_win();
        bit e0, e1;
        e0 = (m0_arvalid === 1'b1) && (m_cnt[0] < MAXO);
        e1 = (m1_arvalid === 1'b1) && (m_cnt[1] < MAXO);
        if (m_sv && !s_arready) return -1;
        if (e0 && e1) return m_pri;
        if (e0) return 0;
        if (e1) return 1;
        return -1;
    endfunction

    always @(posedge clk) begin
        int  w;
        bit  dec [2];
        bit  rhs;
        if (!rst_n) begin
            m_cnt[0] = 0; m_cnt[1] = 0; m_err = 0; m_sv = 0; m_pri = 0;
            m_id = '0; m_addr = '0; m_len = '0;
        end else begin
            w   = exp_win();
            rhs = s_rvalid && (s_rid[3] ? m1_rready : m0_rready);
            dec[0] = rhs && s_rlast && !s_rid[3];
            dec[1] = rhs && s_rlast && s_rid[3];
            if (m_sv && s_arready && auto_r)
                for (int b = 0; b <= int'(m_len); b++)
                    r_q.push_back('{id: m_id, last: (b == int'(m_len))});
            if (!m_sv || s_arready) begin
                m_sv = (w >= 0);
                if (w == 0) begin
                    m_id = {1'b0, m0_arid}; m_addr = m0_araddr; m_len = m0_arlen;
                end else if (w == 1) begin
                    m_id = {1'b1, m1_arid}; m_addr = m1_araddr; m_len = m1_arlen;
                end
                if (w >= 0) m_pri = 1 - w;
            end
            for (int n = 0; n < 2; n++) begin
                if (dec[n] && m_cnt[n] == 0) m_err = 1;
                if ((w == n) && !dec[n]) m_cnt[n]++;
                else if (dec[n] && (w != n) && m_cnt[n] > 0) m_cnt[n]--;
            end
        end
    end

    always @(negedge clk) begin
        int w;
        if (rst_n && chk_en) begin
            w = exp_win();
            chk("s_arvalid", s_arvalid, m_sv);
            if (m_sv) begin
                chk("s_arid", s_arid, m_id);
                chk("s_araddr", s_araddr, m_addr);
                chk("s_arlen", s_arlen, m_len);
            end
            if (m0_arvalid) chk("m0_arready", m0_arready, w == 0);
            if (m1_arvalid) chk("m1_arready", m1_arready, w == 1);
            chk("m0_rvalid", m0_rvalid, s_rvalid && !s_rid[3]);
            chk("m1_rvalid", m1_rvalid, s_rvalid && s_rid[3]);
            chk("s_rready", s_rready, s_rid[3] ? m1_rready : m0_rready);
            chk("rid", {m1_rid, m0_rid}, {s_rid[2:0], s_rid[2:0]});
            chk("rdata", {m1_rdata, m0_rdata}, {s_rdata, s_rdata});
            chk("rlast_rresp", {m1_rlast, m0_rlast, m1_rresp, m0_rresp},
                {s_rlast, s_rlast, s_rresp, s_rresp});
            chk("ost_err", ost_err, m_err);
        end
        if (rst_n && s_arvalid && s_arready) issued.push_back(s_arid[3]);
    end

    // ---------------- stimulus drivers ----------------
    initial begin
        bit a;
        m0_arvalid = 0; m0_arid = 0; m0_araddr = 0; m0_arlen = 0; m0_arsize = 3'd2; m0_arburst = 2'b01;
        forever begin
            @(negedge clk); a = m0_arvalid && m0_arready;
            @(posedge clk); #1;
            if (a && m0_q.size() > 0) void'(m0_q.pop_front());
            m0_arvalid = (m0_q.size() > 0);
            if (m0_q.size() > 0) begin
                m0_arid = m0_q[0].id; m0_araddr = m0_q[0].addr; m0_arlen = m0_q[0].len;
            end
        end
    end

    initial begin
        bit a;
        m1_arvalid = 0; m1_arid = 0; m1_araddr = 0; m1_arlen = 0; m1_arsize = 3'd2; m1_arburst = 2'b01;
        forever begin
            @(negedge clk); a = m1_arvalid && m1_arready;
            @(posedge clk); #1;
            if (a && m1_q.size() > 0) void'(m1_q.pop_front());
            m1_arvalid = (m1_q.size() > 0);
            if (m1_q.size() > 0) begin
                m1_arid = m1_q[0].id; m1_araddr = m1_q[0].addr; m1_arlen = m1_q[0].len;
            end
        end
    end

    initial begin
        bit a;
        s_rvalid = 0; s_rid = 0; s_rlast = 0; s_rdata = 32'hD000_0000; s_rresp = 2'b00;
        forever begin
            @(negedge clk); a = s_rvalid && s_rready;
            @(posedge clk); #1;
            if (a && r_q.size() > 0) begin
                void'(r_q.pop_front());
                s_rdata = s_rdata + 32'd1;
                s_rresp = s_rresp + 2'd1;
            end
            s_rvalid = (r_q.size() > 0);
            if (r_q.size() > 0) begin
                s_rid = r_q[0].id; s_rlast = r_q[0].last;
            end
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < 200 && (m0_q.size() + m1_q.size() + r_q.size()) != 0; i++) @(negedge clk);
        chk("drain", m0_q.size() + m1_q.size() + r_q.size(), 0);
        repeat (n) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n0, n1;
        bit got;
        rst_n = 0; s_arready = 0; m0_rready = 0; m1_rready = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        @(negedge clk);
        chk("rst_s_arvalid", s_arvalid, 0);
        chk("rst_ost_err", ost_err, 0);
        chk("rst_s_ar_payload", {s_arid, s_araddr, s_arlen}, 0);
        chk_en = 1;

        // Both masters stream 4 requests each; alternation starts with m0.
        step(); s_arready = 1; m0_rready = 1; m1_rready = 1; auto_r = 1;
        issued.delete();
        for (int i = 0; i < 4; i++) begin
            m0_q.push_back('{id: 3'(i), addr: 32'h1000 + 32'(i * 16), len: 8'd0});
            m1_q.push_back('{id: 3'(i), addr: 32'h2000 + 32'(i * 16), len: 8'd0});
        end
        idle(4);
        chk("alt_issue_count", issued.size(), 8);
        for (int k = 0; k < 8 && k < issued.size(); k++) chk("alt_issue_order", issued[k], k % 2);

        // Single m0 burst: 1-cycle AR latency, 4 beats to m0 only.
        step(); m0_q.push_back('{id: 3'd2, addr: 32'h10, len: 8'd3});
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = m0_arvalid && m0_arready;
        end
        chk("m0_accept", got, 1);
        @(negedge clk);
        chk("m0_issue", {s_arvalid, s_arid, s_araddr, s_arlen}, {1'b1, 4'h2, 32'h10, 8'd3});
        n0 = 0; n1 = 0;
        for (int i = 0; i < 40 && n0 < 4; i++) begin
            @(negedge clk);
            if (m0_rvalid && m0_rready) n0++;
            if (m1_rvalid) n1++;
        end
        chk("m0_beats", n0, 4);
        chk("m1_beats", n1, 0);
        idle(2);

        // Slave stalls 5 cycles while m1 has another request pending.
        step(); s_arready = 0;
        m1_q.push_back('{id: 3'd5, addr: 32'h100, len: 8'd0});
        m1_q.push_back('{id: 3'd6, addr: 32'h200, len: 8'd0});
        for (int i = 0; i < 20 && m1_q.size() != 1; i++) @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("stall_hold", {s_arvalid, s_arid, s_araddr}, {1'b1, 4'hD, 32'h100});
            chk("stall_arready", {m1_arvalid, m1_arready, m0_arready}, 3'b100);
            @(negedge clk);
        end
        step(); s_arready = 1;
        @(negedge clk);
        chk("stall_release", {m1_arready, s_araddr}, {1'b1, 32'h100});
        idle(2);

        // MAX_OST=2: third m0 request waits for an rlast, m1 keeps going.
        step(); auto_r = 0;
        for (int i = 0; i < 3; i++) m0_q.push_back('{id: 3'(i), addr: 32'h3000 + 32'(i * 4), len: 8'd0});
        for (int i = 0; i < 20 && m0_q.size() != 1; i++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("ost_block_m0", {m0_arvalid, m0_arready}, 2'b10);
        end
        step(); m1_q.push_back('{id: 3'd3, addr: 32'h4000, len: 8'd0});
        for (int i = 0; i < 20 && m1_q.size() != 0; i++) @(negedge clk);
        chk("ost_m1_granted", m1_q.size(), 0);
        chk("ost_m0_still_held", m0_q.size(), 1);
        step(); r_q.push_back('{id: 4'h1, last: 1'b1});
        for (int i = 0; i < 20 && m0_q.size() != 0; i++) @(negedge clk);
        chk("ost_m0_released", m0_q.size(), 0);
        repeat (3) @(negedge clk);

        // R for m1 held off by m1_rready=0.
        step(); m1_rready = 0; r_q.push_back('{id: 4'h9, last: 1'b1});
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("r_backpress", {s_rready, m0_rvalid, m1_rvalid}, 3'b001);
            @(negedge clk);
        end
        step(); m1_rready = 1;
        @(negedge clk);
        chk("r_release", {s_rready, m1_rvalid}, 2'b11);
        idle(2);

        // rlast for m1 with nothing outstanding.
        step(); r_q.push_back('{id: 4'h8, last: 1'b1});
        idle(1);
        chk("ost_err_set", ost_err, 1);
        repeat (4) @(negedge clk);
        chk("ost_err_sticky", ost_err, 1);
        step();
        for (int i = 0; i < 3; i++) m1_q.push_back('{id: 3'(i), addr: 32'h5000 + 32'(i * 4), len: 8'd0});
        for (int i = 0; i < 20 && m1_q.size() != 1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("ost_clamp", {m1_q.size() == 1, m1_arready}, 2'b10);

        // Park a request in the AR stage, then reset asynchronously.
        step(); r_q.push_back('{id: 4'h1, last: 1'b1});
        for (int i = 0; i < 20 && r_q.size() != 0; i++) @(negedge clk);
        step(); s_arready = 0; m0_q.push_back('{id: 3'd7, addr: 32'h6000, len: 8'd0});
        for (int i = 0; i < 20 && m0_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        chk("pre_rst_arvalid", s_arvalid, 1);
        chk_en = 0;
        m0_q.delete(); m1_q.delete(); r_q.delete();
        #2 rst_n = 0;
        #1;
        chk("async_rst", {ost_err, s_arvalid}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1; s_arready = 1; auto_r = 1;
        @(negedge clk);
        chk_en = 1;
        step(); m1_q.push_back('{id: 3'd1, addr: 32'h7000, len: 8'd1});
        idle(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire

// File: doc/easyaxi_rd_arb.md
Name: easyaxi_rd_arb

Overview:
- 2-to-1 AXI read-channel arbiter placed in front of the EasyAXI read slave.
- Lets two masters share one slave with outstanding transactions.
- AR requests are round-robin arbitrated and issued from a registered output stage; the master index is carried in the ID MSB.
- R beats are routed back by that ID bit, and per-master outstanding counters throttle issue.

Parameters:
- MAX_OST, 8, max outstanding bursts per master; range 1..15.
- OST_CNT_W, $clog2(MAX_OST+1), outstanding counter width; derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mN_arvalid  in  1  master N AR valid (N=0,1)
- mN_arready  out  1  master N AR ready
- mN_arid  in  `AXI_ID_W-1  master N AR ID
- mN_araddr/arlen/arsize/arburst  in  `AXI_ADDR_W/`AXI_LEN_W/`AXI_SIZE_W/`AXI_BURST_W  master N AR payload
- mN_rvalid  out  1  master N R valid
- mN_rready  in  1  master N R ready
- mN_rid  out  `AXI_ID_W-1  master N R ID
- mN_rdata/rresp/rlast  out  `AXI_DATA_W/`AXI_RESP_W/1  master N R payload
- s_arvalid  out  1  slave AR valid
- s_arready  in  1  slave AR ready
- s_arid  out  `AXI_ID_W  slave AR ID = {N, mN_arid}
- s_araddr/arlen/arsize/arburst  out  as master  slave AR payload
- s_rvalid  in  1  slave R valid
- s_rready  out  1  slave R ready
- s_rid/rdata/rresp/rlast  in  `AXI_ID_W/`AXI_DATA_W/`AXI_RESP_W/1  slave R payload
- ost_err  out  1  sticky: R beat routed to a master with zero outstanding

Behaviour:
- Reset (async, rst_n=0):
  - s_arvalid=0; all s_ar payload registers 0.
  - ost_cnt[0..1]=0; ost_err=0; last_grant_r=1, so m0 wins the first tie.
- Eligibility: elig[N] = mN_arvalid & (ost_cnt[N] < MAX_OST).
- Load enable: load = ~s_arvalid_r | s_arready.
- Round-robin grant:
  - If both eligible, grant ~last_grant_r; otherwise grant the single eligible master.
  - last_grant_r updates only on an accepted load.
- Handshakes and output register:
  - mN_arready = load & grant[N], combinational. Zero-cycle acceptance is allowed; arready must not depend on mN_arvalid of the same master.
  - On load with a grant: the s_ar payload registers capture the winner and s_arid = {N, mN_arid}; s_arvalid_r <= 1.
  - On load with no grant: s_arvalid_r <= 0.
  - Latency: 1 cycle from master accept to s_arvalid. Throughput: 1 AR per cycle when s_arready is held high.
  - While s_arvalid=1 and s_arready=0, the payload is held stable (AXI rule); no master is accepted.
- R routing:
  - Combinational, no storage.
  - sel = s_rid[`AXI_ID_W-1].
  - mN_rvalid = s_rvalid & (sel==N).
  - s_rready = sel ? m1_rready : m0_rready.
  - mN_rid = s_rid[`AXI_ID_W-2:0]; rdata/rresp/rlast are broadcast to both masters.
- Outstanding counters:
  - inc[N] = mN_arvalid & mN_arready.
  - dec[N] = mN_rvalid & mN_rready & s_rlast.
  - inc and dec in the same cycle leave the count unchanged.
  - A counter at MAX_OST blocks that master only; the other master continues.
- ost_err:
  - Set when dec[N] occurs with ost_cnt[N]==0. The count is clamped at 0 (no underflow) and the beat is still forwarded.
  - Cleared only by reset.
- Reset mid-operation drops any pending s_ar request. The bench must reset the slave together with the arbiter.

Decomposition:
- `AXI_*_W widths and `AXI_BURST_*/`AXI_RESP_* codes come from the shared EasyAXI define file; no new package constants.
- Add localparam MST_NUM=2 and MST_IDX_W=1 to the shared defines so the interconnect can be extended later.
- One natural sub-module: easyaxi_rr_arb2 (2-way round-robin grant with last_grant register and update-enable input).
- The outstanding counter is instantiated inline twice.

Test Plan:
- m0 only, araddr=0x10, arlen=3, arid=2, s_arready=1:
  - s_arvalid one cycle after accept, s_arid=0x2.
  - 4 R beats reach m0 only; ost_cnt[0] goes 1 -> 0 after rlast.
- m0 and m1 assert arvalid continuously, 4 requests each:
  - Issue order m0,m1,m0,m1,...; s_arid MSB alternates 0,1.
- s_arready held low 5 cycles with m1 pending:
  - s_ar payload stable; m0/m1 arready=0 throughout.
  - Issue proceeds the cycle s_arready rises.
- MAX_OST=2, m0 issues 3 requests with no R returned:
  - Third request is stalled (m0_arready=0).
  - m1 is still granted.
  - After one m0 rlast handshake, the third request issues.
- Slave returns R with s_rid MSB=1 while m1_rready=0:
  - s_rready=0, m0_rvalid=0; beat held until m1_rready=1.
- Inject R rlast for m1 with ost_cnt[1]=0:
  - ost_err=1 and stays 1; ost_cnt[1] stays 0.
  - Assert rst_n=0 asynchronously: ost_err and s_arvalid clear immediately.
